pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  - Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.
//  - A 2-entry skid buffer gives full throughput under backpressure and registered in_ready_o.
//  - Synchronous flush squashes in-flight entries for branch/hazard recovery.
//  - Control fields are held apart from the datapath payload so squashed slots become clean bubbles.
// PARAMETERS
//  CTRL_W    8    width of control bundle (RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc, ...)
//  DATA_W    128  width of payload bundle (data1, data2, imm, funct, rs1, rs2, rd, ...)
//  BUBBLE    0    CTRL_W-bit control value driven whenever the slot is empty or flushed
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       reset, asynchronous, active-high
//  flush_i      in   1       synchronous squash of all held entries
//  in_valid_i   in   1       upstream entry present
//  in_ready_o   in/o out 1   stage can accept this cycle
//  in_ctrl_i    in   CTRL_W  upstream control bundle
//  in_data_i    in   DATA_W  upstream payload
//  out_valid_o  out  1       entry presented downstream
//  out_ready_i  in   1       downstream accepts this cycle
//  out_ctrl_o   out  CTRL_W  control bundle; equals BUBBLE when out_valid_o=0
//  out_data_o   out  DATA_W  payload; don't-care when out_valid_o=0
// BEHAVIOUR
//  - Storage: main slot (drives outputs) and skid slot, each with its own valid bit.
//  - States: EMPTY (none valid), ONE (main valid), TWO (main + skid valid).
//  - Handshake events: accept = in_valid_i & in_ready_o; drain = out_valid_o & out_ready_i.
//  - in_ready_o = !skid_valid. It is a registered flop, never combinational from out_ready_i.
//  - Transitions:
//    EMPTY --accept--> ONE; main <= input.
//    ONE --accept & !drain--> TWO; skid <= input.
//    ONE --accept & drain--> ONE; main <= input.
//    ONE --!accept & drain--> EMPTY.
//    TWO --drain--> ONE; main <= skid.
//    No accept is possible in TWO.
//  - Latency: an entry accepted at edge N is on the outputs after edge N. Throughput is 1 entry/cycle while out_ready_i=1.
//  - Ordering is strictly FIFO. No entry is dropped or duplicated without flush.
//  - Flush has priority over accept and drain in the same cycle. Next state is EMPTY.
//    Both control registers <= BUBBLE; payload registers hold their value.
//    The input entry presented in the flush cycle is discarded.
//  - Reset (async, any state, mid-transfer included):
//    out_valid_o=0, in_ready_o=1, out_ctrl_o=BUBBLE, out_data_o=0, skid cleared to 0/BUBBLE. Every flop is reset.
//  - Release of rst_i is sampled synchronously. The first accept is possible on the first edge after deassertion.
//  - out_ctrl_o is forced to BUBBLE from the register, not by output gating. No combinational in->out path exists.
//  - in_valid_i=0 with garbage on ctrl/data has no effect on state.
// CONFIGURATION
//  PIPE_STAGE_STALL_CNT_EN defined:
//    Adds output port stall_cnt_o [31:0].
//    Increments each cycle with out_valid_o & !out_ready_i; saturates at 32'hFFFF_FFFF.
//    Cleared by rst_i only; flush does not clear it.
//  PIPE_STAGE_STALL_CNT_EN undefined: port and counter are absent. Behaviour is otherwise identical.
// TESTING
//  1. Reset mid-stream (state TWO, rst_i pulsed between edges) -> outputs immediately valid=0, ctrl=BUBBLE,
//     data=0, in_ready=1. Next push of ctrl=8'h5A, data=128'h1 appears 1 cycle later.
//  2. Streaming with out_ready_i=1: 16 entries, data=0..15, valid every cycle ->
//     out_data 0..15 in order, 1-cycle latency, in_ready never drops.
//  3. Backpressure: push A,B,C while out_ready_i=0 -> A held on outputs, B in skid,
//     in_ready=0 after B, C not accepted. Raise out_ready -> A,B then C (re-presented) in order.
//  4. Flush in TWO with in_valid=1 (entry D) -> next cycle out_valid=0, out_ctrl=BUBBLE,
//     in_ready=1; D never appears downstream.
//  5. Simultaneous accept+drain in ONE for 8 cycles -> state stays ONE, zero bubbles, order preserved.
//  6. With PIPE_STAGE_STALL_CNT_EN: hold out_ready=0 for 7 cycles with out_valid=1 -> stall_cnt_o=7.
//     Flush -> count remains 7. Reset -> 0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with a valid/ready handshake.
// A main slot drives the outputs; a skid slot absorbs the one extra entry that
// can arrive in the cycle backpressure appears, so in_ready_o can be a flop.
// Control and payload are stored separately: control is forced to BUBBLE in
// the register whenever a slot empties or is flushed, payload simply holds.
// Optional feature: define PIPE_STAGE_STALL_CNT_EN to add stall_cnt_o, a
// saturating count of cycles where an entry is offered but not taken.
module pipe_stage_skid #(
    parameter int                CTRL_W = 8,
    parameter int                DATA_W = 128,
    parameter logic [CTRL_W-1:0] BUBBLE = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // What the main slot loads on the next edge.
    typedef enum logic [1:0] {
        MS_HOLD = 2'd0,
        MS_IN   = 2'd1,
        MS_SKID = 2'd2,
        MS_BUB  = 2'd3
    } main_sel_t;

    state_t    state_q;
    state_t    state_d;
    main_sel_t main_sel;
    logic      ld_skid;
    logic      clr_skid;
    logic      in_ready_q;
    logic      vld_p0;
    logic      accept;
    logic      drain;

    logic [CTRL_W-1:0] main_ctrl_p0;
    logic [DATA_W-1:0] main_data_p0;
    logic [CTRL_W-1:0] skid_ctrl_p1;
    logic [DATA_W-1:0] skid_data_p1;

    assign vld_p0 = (state_q != ST_EMPTY);
    assign accept = in_valid_i & in_ready_q;
    assign drain  = vld_p0 & out_ready_i;

    // Next-state and slot-load decisions; flush overrides every handshake.
    always_comb begin
        state_d  = state_q;
        main_sel = MS_HOLD;
        ld_skid  = 1'b0;
        clr_skid = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d  = ST_ONE;
                        main_sel = MS_IN;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_sel = MS_IN;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        ld_skid = 1'b1;
                    end else if (drain) begin
                        state_d  = ST_EMPTY;
                        main_sel = MS_BUB;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        state_d  = ST_ONE;
                        main_sel = MS_SKID;
                        clr_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State register plus registered ready, precomputed from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    // ---- main slot (stage p0): drives the outputs ----
    // Main slot: control goes to BUBBLE when emptied/flushed, payload holds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_ctrl_p0 <= BUBBLE;
            main_data_p0 <= '0;
        end else if (flush_i) begin
            main_ctrl_p0 <= BUBBLE;
        end else begin
            case (main_sel)
                MS_IN: begin
                    main_ctrl_p0 <= in_ctrl_i;
                    main_data_p0 <= in_data_i;
                end
                MS_SKID: begin
                    main_ctrl_p0 <= skid_ctrl_p1;
                    main_data_p0 <= skid_data_p1;
                end
                MS_BUB: begin
                    main_ctrl_p0 <= BUBBLE;
                end
                default: begin
                end
            endcase
        end
    end

    // ---- skid slot (stage p1): second entry caught under backpressure ----
    // Skid slot: captures the overflow entry, returns to BUBBLE when vacated.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_ctrl_p1 <= BUBBLE;
            skid_data_p1 <= '0;
        end else if (flush_i || clr_skid) begin
            skid_ctrl_p1 <= BUBBLE;
        end else if (ld_skid) begin
            skid_ctrl_p1 <= in_ctrl_i;
            skid_data_p1 <= in_data_i;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = vld_p0;
    assign out_ctrl_o  = main_ctrl_p0;
    assign out_data_o  = main_data_p0;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        if (cnt == 32'hFFFF_FFFF) begin
            return cnt;
        end
        return cnt + 32'd1;
    endfunction

    // Stall counter: counts offered-but-refused cycles; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (vld_p0 && !out_ready_i) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
